// File: rtl/paralelo_serial_pkg.sv
// Framing constants shared by the serial transmitter and the matching receiver.
package paralelo_serial_pkg;

  localparam int unsigned CANTIDAD_BITS_DEF = 10;
  localparam logic [9:0]  PALABRA_COMA      = 10'h0FA;

  // Bit counter width for a frame of 'bits' bits; never narrower than one bit.
  function automatic int unsigned ancho_contador(input int unsigned bits);
    return (bits > 2) ? $clog2(bits) : 1;
  endfunction

endpackage

// File: rtl/paralelo_serial_registro_retencion.sv
// Single-word holding register between the upstream handshake and the frame loader.
module registro_retencion
  import paralelo_serial_pkg::*;
#(
  parameter int unsigned cantidadBits = CANTIDAD_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frontera,
  input  logic                    valido,
  input  logic [cantidadBits-1:0] entradas,
  output logic [cantidadBits-1:0] palabra,
  output logic                    lleno,
  output logic                    listo
);

  logic transferencia;

  // The slot frees up on a boundary, so a new word can land in the same cycle.
  assign listo         = !lleno || frontera;
  assign transferencia = valido && listo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      palabra <= '0;
      lleno   <= 1'b0;
    end else if (transferencia) begin
      palabra <= entradas;
      lleno   <= 1'b1;
    end else if (frontera) begin
      lleno   <= 1'b0;
    end
  end

endmodule

// File: rtl/paralelo_serial.sv
// Parallel-to-serial transmitter: LSB first, one bit per enabled cycle, idle word fill.
module paralelo_serial
  import paralelo_serial_pkg::*;
#(
  parameter int unsigned              cantidadBits = CANTIDAD_BITS_DEF,
  parameter logic [cantidadBits-1:0]  PALABRA_IDLE = cantidadBits'(PALABRA_COMA)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enb,
  input  logic [cantidadBits-1:0] entradas,
  input  logic                    valido,
  output logic                    listo,
  output logic                    salida,
  output logic                    inicio,
  output logic                    dato_activo
);

  localparam int unsigned CW = ancho_contador(cantidadBits);
  localparam logic [CW-1:0] ULTIMO = CW'(cantidadBits - 1);

  logic [CW-1:0]           contador;
  logic [cantidadBits-1:0] shreg;
  logic [cantidadBits-1:0] palabra_ret;
  logic [cantidadBits-1:0] palabra;
  logic                    lleno;
  logic                    frontera;

  assign frontera = enb && (contador == ULTIMO);
  assign palabra  = lleno ? palabra_ret : PALABRA_IDLE;

  registro_retencion #(
    .cantidadBits(cantidadBits)
  ) u_retencion (
    .clk      (clk),
    .rst      (rst),
    .frontera (frontera),
    .valido   (valido),
    .entradas (entradas),
    .palabra  (palabra_ret),
    .lleno    (lleno),
    .listo    (listo)
  );

  // Counter resets to the last bit so the first enabled cycle loads a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      contador    <= ULTIMO;
      shreg       <= '0;
      salida      <= 1'b0;
      inicio      <= 1'b0;
      dato_activo <= 1'b0;
    end else if (enb) begin
      if (frontera) begin
        salida      <= palabra[0];
        shreg       <= palabra >> 1;
        inicio      <= 1'b1;
        dato_activo <= lleno;
        contador    <= '0;
      end else begin
        salida   <= shreg[0];
        shreg    <= shreg >> 1;
        inicio   <= 1'b0;
        contador <= contador + CW'(1);
      end
    end
  end

endmodule
